// File: rtl/dmem_responder.sv
// Word-addressed 64-bit data memory serving one load/store at a time over valid/ready
// request and response channels, with configurable response latency, halt drain and statistics.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] req_count,
  output logic [15:0] err_count
);

  localparam int DATA_W = 64;
  localparam int AW     = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, HALTED} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          lat_cnt;
  logic                halt_pend;
  logic [DATA_W-1:0]   mem [DEPTH_WORDS];
  logic                accept;
  logic                addr_err;
  logic [AW-1:0]       word_idx;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign word_idx   = req_addr[AW+2:3];
  assign addr_err   = (req_addr[2:0] != 3'b000) || (req_addr[63:AW+3] != '0);
  // reset is folded in so req_ready drops the moment reset asserts, not at the next edge
  assign req_ready  = (state == IDLE) && !halt && reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign halted     = (state == HALTED);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (halt) state_nxt = HALTED;
               else if (accept) state_nxt = BUSY;
      BUSY:    if (lat_cnt == 4'd0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = (halt || halt_pend) ? HALTED : IDLE;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= 4'd0;
      halt_pend  <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      req_count  <= '0;
      err_count  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_cnt    <= 4'(LATENCY - 1);
        req_count  <= req_count + 32'd1;
        resp_err   <= addr_err;
        resp_rdata <= (!req_write && !addr_err) ? mem[word_idx] : '0;
        if (addr_err) err_count <= sat_inc16(err_count);
      end else if (state == BUSY && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if ((state == BUSY || state == RESP) && halt) halt_pend <= 1'b1;
    end
  end

  // Array has no reset; a store lands at acceptance so it survives a later abort.
  always_ff @(posedge clk) begin
    if (accept && req_write && !addr_err) mem[word_idx] <= req_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for load/store/error cases plus
// hand-written sequences for backpressure, halt, mid-transaction reset and latency extremes.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err, halt, halted;
  logic [31:0] req_count;
  logic [15:0] err_count;

  logic        s_write, s_resp_ready, s_halt;
  logic [63:0] s_addr, s_wdata;
  logic        s_valid1, ready1, valid1, err1, halted1;
  logic [63:0] rdata1;
  logic [31:0] rc1;
  logic [15:0] ec1;
  logic        s_valid15, ready15, valid15, err15, halted15;
  logic [63:0] rdata15;
  logic [31:0] rc15;
  logic [15:0] ec15;

  int n_cmp;
  int n_fail;

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .halt(halt), .halted(halted),
    .req_count(req_count), .err_count(err_count)
  );

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(s_valid1), .req_ready(ready1),
    .req_write(s_write), .req_addr(s_addr), .req_wdata(s_wdata),
    .resp_valid(valid1), .resp_ready(s_resp_ready), .resp_rdata(rdata1),
    .resp_err(err1), .halt(s_halt), .halted(halted1),
    .req_count(rc1), .err_count(ec1)
  );

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(15)) dut15 (
    .clk(clk), .reset(reset), .req_valid(s_valid15), .req_ready(ready15),
    .req_write(s_write), .req_addr(s_addr), .req_wdata(s_wdata),
    .resp_valid(valid15), .resp_ready(s_resp_ready), .resp_rdata(rdata15),
    .resp_err(err15), .halt(s_halt), .halted(halted15),
    .req_count(rc15), .err_count(ec15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_rc;
    logic [15:0] exp_ec;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request on the main instance; returns observed response and latency.
  task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                     output logic [63:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (resp_ready) @(negedge clk);
  endtask

  task automatic txn1(input logic w, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic er, output int lat);
    s_valid1 = 1'b1; s_write = w; s_addr = a; s_wdata = d;
    @(posedge clk);
    @(negedge clk);
    s_valid1 = 1'b0;
    lat = 0;
    while (!valid1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata1;
    er = err1;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          lat1, lat15;

    n_cmp = 0; n_fail = 0;
    reset = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1; halt = 1'b0;
    s_valid1 = 0; s_valid15 = 0; s_write = 0; s_addr = '0; s_wdata = '0;
    s_resp_ready = 1'b1; s_halt = 1'b0;

    vecs[0]  = '{1'b1, 64'h10, 64'hDEADBEEF_01234567, 64'h0, 1'b0, 32'd1, 16'd0};
    vecs[1]  = '{1'b0, 64'h10, 64'h0, 64'hDEADBEEF_01234567, 1'b0, 32'd2, 16'd0};
    vecs[2]  = '{1'b1, 64'hFF8, 64'h11112222_33334444, 64'h0, 1'b0, 32'd3, 16'd0};
    vecs[3]  = '{1'b0, 64'h13, 64'h0, 64'h0, 1'b1, 32'd4, 16'd1};
    vecs[4]  = '{1'b1, 64'h1000, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1, 32'd5, 16'd2};
    vecs[5]  = '{1'b0, 64'hFF8, 64'h0, 64'h11112222_33334444, 1'b0, 32'd6, 16'd2};
    vecs[6]  = '{1'b1, 64'h8, 64'h01234567_89ABCDEF, 64'h0, 1'b0, 32'd7, 16'd2};
    vecs[7]  = '{1'b0, 64'h8, 64'h0, 64'h01234567_89ABCDEF, 1'b0, 32'd8, 16'd2};
    vecs[8]  = '{1'b1, 64'h80000000_00000010, 64'h55555555_55555555, 64'h0, 1'b1, 32'd9, 16'd3};
    vecs[9]  = '{1'b0, 64'h10, 64'h0, 64'hDEADBEEF_01234567, 1'b0, 32'd10, 16'd3};
    vecs[10] = '{1'b1, 64'h14, 64'h99999999_99999999, 64'h0, 1'b1, 32'd11, 16'd4};
    vecs[11] = '{1'b0, 64'h10, 64'h0, 64'hDEADBEEF_01234567, 1'b0, 32'd12, 16'd4};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_req_count", 64'(req_count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_ready1", 64'(ready1), 64'd0);
    chk("rst_counts15", 64'({halted15, rc15, ec15}), 64'd0);
    reset = 1'b1;
    #1;
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Vector table, resp_ready held high
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'd1);
      txn(vecs[i].w, vecs[i].a, vecs[i].d, rd, er, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_req_count", i), 64'(req_count), 64'(vecs[i].exp_rc));
      chk($sformatf("v%0d_err_count", i), 64'(err_count), 64'(vecs[i].exp_ec));
    end

    // Response backpressure
    resp_ready = 1'b0;
    txn(1'b0, 64'h8, 64'h0, rd, er, lat);
    chk("bp_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_rdata", resp_rdata, 64'h01234567_89ABCDEF);
      chk("bp_resp_err", 64'(resp_err), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after", 64'(req_ready), 64'd1);
    chk("bp_valid_after", 64'(resp_valid), 64'd0);

    // Halt pulse during BUSY
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("hb_resp_valid", 64'(resp_valid), 64'd1);
    chk("hb_resp_rdata", resp_rdata, 64'hDEADBEEF_01234567);
    chk("hb_not_halted_yet", 64'(halted), 64'd0);
    @(negedge clk);
    chk("hb_halted", 64'(halted), 64'd1);
    chk("hb_resp_valid_off", 64'(resp_valid), 64'd0);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hb_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("hb_req_count", 64'(req_count), 64'd14);
    chk("hb_still_halted", 64'(halted), 64'd1);

    // Halt together with a request in IDLE
    pulse_reset();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h18; req_wdata = 64'h1;
    halt = 1'b1;
    #1;
    chk("hi_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    halt = 1'b0;
    req_valid = 1'b0;
    chk("hi_req_count", 64'(req_count), 64'd0);
    chk("hi_halted", 64'(halted), 64'd1);
    @(negedge clk);
    chk("hi_halted_stays", 64'(halted), 64'd1);

    // Reset while a stored response is waiting in RESP
    pulse_reset();
    resp_ready = 1'b0;
    txn(1'b1, 64'h30, 64'hCAFEF00D_12345678, rd, er, lat);
    chk("mr_latency", 64'(lat), 64'd2);
    chk("mr_count_before", 64'(req_count), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_resp_valid", 64'(resp_valid), 64'd0);
    chk("mr_req_count", 64'(req_count), 64'd0);
    chk("mr_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    resp_ready = 1'b1;
    txn(1'b0, 64'h30, 64'h0, rd, er, lat);
    chk("mr_readback", rd, 64'hCAFEF00D_12345678);
    chk("mr_readback_err", 64'(er), 64'd0);

    // Latency extremes, both instances accept on the same edge
    lat1 = -1; lat15 = -1;
    s_valid1 = 1'b1; s_valid15 = 1'b1;
    s_write = 1'b1; s_addr = 64'h40; s_wdata = 64'hA5A5A5A5_5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    s_valid1 = 1'b0; s_valid15 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (valid1 && lat1 < 0) lat1 = k;
      if (valid15 && lat15 < 0) begin
        lat15 = k;
        chk("l15_store_rdata", rdata15, 64'd0);
        chk("l15_store_err", 64'(err15), 64'd0);
      end
      @(negedge clk);
    end
    chk("lat1", 64'(lat1), 64'd1);
    chk("lat15", 64'(lat15), 64'd15);
    chk("l15_ready", 64'(ready15), 64'd1);

    // Counter wrap on the LATENCY=1 instance
    force dut1.req_count = 32'hFFFF_FFFE;
    #1;
    release dut1.req_count;
    txn1(1'b0, 64'h40, 64'h0, rd, er, lat);
    chk("wrap_lat", 64'(lat), 64'd1);
    chk("wrap_rdata", rd, 64'hA5A5A5A5_5A5A5A5A);
    chk("wrap_count1", 64'(rc1), 64'hFFFF_FFFF);
    txn1(1'b0, 64'h41, 64'h0, rd, er, lat);
    chk("wrap_err", 64'(er), 64'd1);
    chk("wrap_count2", 64'(rc1), 64'd0);
    txn1(1'b0, 64'h40, 64'h0, rd, er, lat);
    chk("wrap_count3", 64'(rc1), 64'd1);
    chk("wrap_err_count", 64'(ec1), 64'd1);
    chk("wrap_halted", 64'(halted1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
